// File: rtl/syn_down_ld.sv
// -----------------------------------------------------------------------------
// syn_down_ld -- loadable synchronous down counter
//
// Purpose:
//   Down counter for timeouts, interval ticks and delays. Supports three modes:
//   free-running wrap (00, and 11 which behaves as 00), periodic auto-reload
//   (01) and one-shot (10). Count, terminal-count pulse and one-shot done flag
//   are registered; qbar is the combinational complement of the registered q.
//
// Ports:
//   clk   in   1      rising-edge clock
//   clr   in   1      synchronous active-high reset, highest priority
//   pre   in   1      synchronous preset, forces q to all ones
//   en    in   1      count enable, one decrement step per edge
//   load  in   1      synchronous load of din into q and the reload register
//   din   in   WIDTH  load value / reload value
//   mode  in   2      00 wrap, 01 auto-reload, 10 one-shot, 11 as 00
//   q     out  WIDTH  current count
//   qbar  out  WIDTH  ~q
//   tc    out  1      one-cycle pulse after a count step moved q from 1 to 0
//   done  out  1      one-shot expired flag
// -----------------------------------------------------------------------------
module syn_down_ld #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pre,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] L_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] L_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] L_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rld;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_rld_nxt;
  logic             w_tc_nxt;
  logic             w_done_nxt;
  logic             w_at_one;
  logic             w_at_zero;

  assign w_at_one  = (r_q == L_ONE);
  assign w_at_zero = (r_q == L_ZERO);

  // Next-state decode: clr > pre > load > enabled count step > hold.
  always_comb begin
    w_q_nxt    = r_q;
    w_rld_nxt  = r_rld;
    w_tc_nxt   = 1'b0;
    w_done_nxt = r_done;
    if (clr) begin
      w_q_nxt    = L_ZERO;
      w_rld_nxt  = L_ZERO;
      w_done_nxt = 1'b0;
    end else if (pre) begin
      w_q_nxt    = L_ONES;
      w_done_nxt = 1'b0;
    end else if (load) begin
      w_q_nxt    = din;
      w_rld_nxt  = din;
      // Loading zero in one-shot mode means the shot has already expired.
      w_done_nxt = (mode == 2'b10) && (din == L_ZERO);
    end else if (en) begin
      // Every mode steps 1 -> 0 the same way, so tc is mode independent.
      w_tc_nxt = w_at_one;
      case (mode)
        2'b01: begin
          if (w_at_zero) begin
            w_q_nxt = r_rld;
          end else begin
            w_q_nxt = r_q - L_ONE;
          end
        end
        2'b10: begin
          if (w_at_zero) begin
            w_q_nxt = L_ZERO;
          end else begin
            w_q_nxt = r_q - L_ONE;
          end
          if (w_at_one) begin
            w_done_nxt = 1'b1;
          end else begin
            w_done_nxt = r_done;
          end
        end
        default: begin
          w_q_nxt = r_q - L_ONE;
        end
      endcase
    end else begin
      w_q_nxt = r_q;
    end
  end

  // State registers with synchronous clear folded into the next-state logic.
  always_ff @(posedge clk) begin
    r_q    <= w_q_nxt;
    r_rld  <= w_rld_nxt;
    r_tc   <= w_tc_nxt;
    r_done <= w_done_nxt;
  end

  assign q    = r_q;
  assign qbar = ~r_q;
  assign tc   = r_tc;
  assign done = r_done;

endmodule

// File: tb/tb_syn_down_ld.sv
// -----------------------------------------------------------------------------
// tb_syn_down_ld -- self-checking bench for syn_down_ld (WIDTH=4)
//   Directed vector table, hand-written multi-cycle sequence, and a randomized
//   run compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_syn_down_ld;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clr, pre, en, load;
  logic [W-1:0] din;
  logic [1:0]   mode;
  logic [W-1:0] q, qbar;
  logic         tc, done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_q, m_rld, m_done, m_tc;

  typedef struct {
    logic       clr, pre, en, load;
    logic [3:0] din;
    logic [1:0] mode;
    int         q, tc, done;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  syn_down_ld #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .pre(pre), .en(en), .load(load),
    .din(din), .mode(mode), .q(q), .qbar(qbar), .tc(tc), .done(done)
  );

  function automatic vec_t v(input logic c, input logic p, input logic e,
                             input logic l, input int d, input int md,
                             input int eq, input int et, input int ed);
    vec_t r;
    r.clr = c; r.pre = p; r.en = e; r.load = l;
    r.din = 4'(d); r.mode = 2'(md);
    r.q = eq; r.tc = et; r.done = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int eq, input int et, input int ed);
    chk({tag, ".q"}, int'(q), eq);
    chk({tag, ".qbar"}, int'(qbar), (~eq) & MAXV);
    chk({tag, ".tc"}, int'(tc), et);
    chk({tag, ".done"}, int'(done), ed);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic p, input logic e,
                       input logic l, input int d, input int md);
    clr = c; pre = p; en = e; load = l; din = 4'(d); mode = 2'(md);
  endtask

  // Reference model: applies the counter rules to the current inputs.
  task automatic model_step;
    int nq, nd, nt;
    nq = m_q; nd = m_done; nt = 0;
    if (clr) begin
      nq = 0; m_rld = 0; nd = 0;
    end else if (pre) begin
      nq = MAXV; nd = 0;
    end else if (load) begin
      nq = int'(din); m_rld = int'(din);
      nd = (mode == 2'd2 && din == 4'd0) ? 1 : 0;
    end else if (en) begin
      if (mode == 2'd1)      nq = (m_q == 0) ? m_rld : m_q - 1;
      else if (mode == 2'd2) begin
        nq = (m_q == 0) ? 0 : m_q - 1;
        if (m_q == 1) nd = 1;
      end else               nq = (m_q + MAXV) % (MAXV + 1);
      nt = (m_q == 1) ? 1 : 0;
    end
    m_q = nq; m_done = nd; m_tc = nt;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);

    // ---------------- directed vector table ----------------
    //        clr pre en ld din md   q tc done
    tbl.push_back(v(1, 0, 1, 1, 7, 0,  0, 0, 0)); // reset
    tbl.push_back(v(1, 0, 1, 1, 7, 0,  0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 7, 0,  0, 0, 0)); // released, idle
    tbl.push_back(v(0, 0, 0, 1, 3, 0,  3, 0, 0)); // wrap mode
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  2, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0,  0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0)); // en gap
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 15, 0, 0)); // wrap, no tc
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 14, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 2, 1,  2, 0, 0)); // auto-reload
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  2, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  0, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  2, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1,  0, 0, 0)); // reload value 0
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 2, 2,  2, 0, 0)); // one-shot
    tbl.push_back(v(0, 0, 1, 0, 0, 2,  1, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 2,  0, 1, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 2,  0, 0, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 2,  0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 1)); // mode change, done kept
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 15, 0, 1)); // wraps, done still kept
    tbl.push_back(v(0, 0, 0, 1, 5, 2,  5, 0, 0)); // reload clears done
    tbl.push_back(v(0, 0, 0, 1, 0, 2,  0, 0, 1)); // load 0 one-shot
    tbl.push_back(v(0, 1, 0, 1, 3, 1, 15, 0, 0)); // pre beats load
    tbl.push_back(v(1, 1, 1, 0, 0, 0,  0, 0, 0)); // clr beats pre
    tbl.push_back(v(0, 0, 0, 1, 9, 0,  9, 0, 0)); // load with en=0
    tbl.push_back(v(0, 0, 0, 1, 0, 3,  0, 0, 0)); // mode 11 acts as wrap
    tbl.push_back(v(0, 0, 1, 0, 0, 3, 15, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 12, 1, 12, 0, 0)); // reset mid-count
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 11, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 10, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  9, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 1,  0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  0, 0, 0)); // rld cleared to 0
    tbl.push_back(v(0, 0, 1, 0, 0, 1,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].pre, tbl[i].en, tbl[i].load,
            int'(tbl[i].din), int'(tbl[i].mode));
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].tc, tbl[i].done);
    end

    // ---------------- preset keeps the reload register ----------------
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 1, 1); tick();
    check_all("rld_load", 1, 0, 0);
    drive(0, 1, 0, 1, 3, 1); tick();
    check_all("rld_pre", 15, 0, 0);
    for (int k = 0; k < 15; k++) begin
      drive(0, 0, 1, 0, 0, 1); tick();
      check_all($sformatf("rld_cnt%0d", k), 14 - k, (k == 14) ? 1 : 0, 0);
    end
    drive(0, 0, 1, 0, 0, 1); tick();
    check_all("rld_reload", 1, 0, 0);

    // ---------------- randomized run vs. reference model ----------------
    begin
      int cur_mode;
      cur_mode = 0;
      m_q = 0; m_rld = 0; m_done = 0; m_tc = 0;
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 15) == 0) cur_mode = $urandom_range(0, 3);
        drive((i == 0) || ($urandom_range(0, 59) == 0),
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0,
              ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : $urandom_range(0, MAXV),
              cur_mode);
        model_step();
        tick();
        check_all($sformatf("rnd%0d", i), m_q, m_tc, m_done);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_down_ld.md
Name: syn_down_ld

Overview:
- Loadable synchronous down counter. It is the counting-down counterpart of the team's synchronous up counter, used for timeouts, interval ticks and delays.
- Three modes: free-running wrap, periodic auto-reload, and one-shot.
- Outputs are registered: count, its complement, a terminal-count pulse and a one-shot done flag. These feed timing/control logic elsewhere in the design.

Parameters:
- WIDTH, 4, counter width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset; highest priority.
- pre  input  1  synchronous preset; forces count to all ones.
- en  input  1  count enable; one decrement step per clk edge while high.
- load  input  1  synchronous load of din.
- din  input  WIDTH  load value; also captured as the reload value.
- mode  input  2  00 wrap, 01 auto-reload, 10 one-shot, 11 treated as 00.
- q  output  WIDTH  current count.
- qbar  output  WIDTH  bitwise complement of q, always equal to ~q.
- tc  output  1  terminal-count pulse, one cycle.
- done  output  1  one-shot expired flag.

Behaviour:
- All state updates occur on the rising edge of clk. Outputs are registered except qbar, which is ~q.
- Internal state is q, rld (the reload register, WIDTH bits), tc and done.
- Per-edge priority is clr > pre > load > count.
- clr=1:
  - q=0, rld=0, tc=0, done=0.
  - Applies regardless of en, load, pre or mode.
  - Mid-count clr zeroes q at that edge with no tc.
- pre=1 (clr=0): q = all ones, tc=0, done=0, rld unchanged.
- load=1 (clr=pre=0):
  - q=din and rld=din, independent of en. tc=0.
  - done=1 if mode=10 and din=0; otherwise done=0.
- Count step (en=1, no clr/pre/load), by mode:
  - Mode 00/11: q=q-1 modulo 2^WIDTH, so 0 wraps to all ones.
  - Mode 01: if q≠0 then q=q-1, else q=rld. Period is rld+1 enabled cycles. If rld=0, q stays 0.
  - Mode 10:
    - If q≠0, q=q-1.
    - If q=0, q holds at 0 and done stays set.
    - When q goes 1→0, done=1 at that same edge.
- tc:
  - tc=1 for exactly the one cycle following an edge where a count step moved q from 1 to 0. Otherwise tc=0.
  - No tc on clr, pre, on loading 0, on a reload of 0 in mode 01, on a wrap 0→max, or on holding at 0 in mode 10.
- en=0 (no clr/pre/load): q, rld and done hold; tc=0.
- Mode changes take effect at the next enabled edge. done is only ever set in mode 10. A done already set persists across a mode change until clr, pre or load.
- Latency: q reflects any control action one edge after it is sampled.

Test Plan (WIDTH=4):
- Reset: clr=1 for 2 cycles with en=1, load=1, din=7 → q=0000, qbar=1111, tc=0, done=0. Release clr → q stays 0 until en/load.
- Wrap mode: mode=00, load din=3, then en=1 → q = 3,2,1,0,15,14,… with tc=1 only in the cycle q=0. An en=0 gap mid-sequence holds q with tc=0.
- Auto-reload: mode=01, load din=2, en=1 → q = 2,1,0,2,1,0,2; tc high in each q=0 cycle (every 3rd cycle). Load din=0 → q stays 0, tc never asserts.
- One-shot:
  - mode=10, load din=2, en=1 → q = 2,1,0,0,0; tc pulses once when q first reads 0; done=1 from that cycle on.
  - Load din=5 → done=0, q=5.
  - Load din=0 → done=1 next cycle, tc=0.
- Priority:
  - pre=1 and load=1 together (din=3) → q=1111, rld unchanged.
  - clr=1 with pre=1 → q=0.
  - load with en=0 → q=din.
- Reset mid-operation: mode=01, rld=12, assert clr at q=9 → q=0, rld=0, tc=0 next cycle. Subsequent en=1 keeps q=0 with no tc.
